// File: rtl/vx_csr_drain_gate.sv
// vx_csr_drain_gate
// Holds one CSR request until every older in-flight instruction of the same
// warp has committed, then hands it to the CSR unit. Per-warp in-flight
// counters are kept from issue/commit events and also drive alm_empty.
// Optional build macro: VX_CSR_DRAIN_PERF_EN adds perf_drain_cycles and
// perf_csr_reqs counters and ports.
module vx_csr_drain_gate #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_COMMIT  = 4,
  parameter int MAX_PENDING = 15,
  parameter int DATAW       = 128,
  parameter int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue_valid,
  input  logic [WID_W-1:0]            issue_wid,
  input  logic [NUM_COMMIT-1:0]       commit_valid,
  input  logic [NUM_COMMIT*WID_W-1:0] commit_wid,
  input  logic                        csr_in_valid,
  output logic                        csr_in_ready,
  input  logic [WID_W-1:0]            csr_in_wid,
  input  logic [DATAW-1:0]            csr_in_data,
  output logic                        csr_out_valid,
  input  logic                        csr_out_ready,
  output logic [DATAW-1:0]            csr_out_data,
  input  logic [WID_W-1:0]            alm_empty_wid,
  output logic                        alm_empty,
  output logic                        err_overflow
`ifdef VX_CSR_DRAIN_PERF_EN
  ,
  output logic [63:0]                 perf_drain_cycles,
  output logic [31:0]                 perf_csr_reqs
`endif
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  // Wide enough to hold count + 1 issue - NUM_COMMIT commits without wrap.
  localparam int AW    = CNT_W + $clog2(NUM_COMMIT + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, SEND} state_e;

  state_e              state_q, state_d;
  logic [WID_W-1:0]    wid_q;
  logic [DATAW-1:0]    data_q;
  logic                err_q;
  logic [NUM_WARPS-1:0] zero_vec;   // registered pending[w] == 0
  logic [NUM_WARPS-1:0] issue_vec;  // issue this cycle targets warp w
  logic [NUM_WARPS-1:0] ovf_vec;    // warp w clamped this cycle

  // Per-warp in-flight counter with saturating/clamping update.
  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    up, dn;
    logic             ovf;

    // Net issue/commit arithmetic with clamping at 0 and MAX_PENDING.
    always_comb begin
      dn = '0;
      for (int i = 0; i < NUM_COMMIT; i++) begin
        if (commit_valid[i] && (commit_wid[i*WID_W +: WID_W] == WID_W'(gi)))
          dn = dn + AW'(1);
      end
      up  = AW'(cnt_q) + (issue_vec[gi] ? AW'(1) : AW'(0));
      ovf = 1'b0;
      if (dn > up) begin
        cnt_d = '0;
        ovf   = 1'b1;
      end else if ((up - dn) > AW'(MAX_PENDING)) begin
        cnt_d = CNT_W'(MAX_PENDING);
        ovf   = 1'b1;
      end else begin
        cnt_d = CNT_W'(up - dn);
      end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign issue_vec[gi] = issue_valid && (issue_wid == WID_W'(gi));
    assign zero_vec[gi]  = (cnt_q == '0);
    assign ovf_vec[gi]   = ovf;
  end

  // A warp is drained when its registered count is zero and nothing is being
  // issued to it right now. Untracked warp IDs have nothing in flight.
  function automatic logic drained(input logic [WID_W-1:0] w);
    if (32'(w) >= NUM_WARPS) return 1'b1;
    return zero_vec[w] && !issue_vec[w];
  endfunction

  assign alm_empty    = (32'(alm_empty_wid) >= NUM_WARPS) || zero_vec[alm_empty_wid];
  assign csr_out_data = data_q;
  assign err_overflow = err_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: accept, wait for drain, then wait for the CSR unit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (csr_in_valid) state_d = drained(csr_in_wid) ? SEND : DRAIN;
      DRAIN:   if (drained(wid_q)) state_d = SEND;
      SEND:    if (csr_out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    csr_in_ready  = (state_q == IDLE);
    csr_out_valid = (state_q == SEND);
  end

  // Capture the request into the hold registers on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wid_q  <= '0;
      data_q <= '0;
    end else if ((state_q == IDLE) && csr_in_valid) begin
      wid_q  <= csr_in_wid;
      data_q <= csr_in_data;
    end
  end

  // Sticky overflow/underflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_q | (|ovf_vec);
  end

`ifdef VX_CSR_DRAIN_PERF_EN
  logic [63:0] perf_drain_q;
  logic [31:0] perf_reqs_q;

  // Stall cycles (draining or back-pressured) and accepted-request counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_drain_q <= '0;
      perf_reqs_q  <= '0;
    end else begin
      if ((state_q == DRAIN) || ((state_q == SEND) && !csr_out_ready))
        perf_drain_q <= perf_drain_q + 64'd1;
      if ((state_q == IDLE) && csr_in_valid)
        perf_reqs_q <= perf_reqs_q + 32'd1;
    end
  end

  assign perf_drain_cycles = perf_drain_q;
  assign perf_csr_reqs     = perf_reqs_q;
`endif

endmodule

// File: tb/tb_vx_csr_drain_gate.sv
// Self-checking bench for vx_csr_drain_gate: directed scenarios followed by a
// randomized run, all checked against a per-cycle behavioural model.
module tb_vx_csr_drain_gate;

  localparam int NW = 4;
  localparam int NC = 4;
  localparam int MP = 15;
  localparam int DW = 128;
  localparam int WW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           issue_valid;
  logic [WW-1:0]  issue_wid;
  logic [NC-1:0]  commit_valid;
  logic [NC*WW-1:0] commit_wid;
  logic           csr_in_valid;
  logic           csr_in_ready;
  logic [WW-1:0]  csr_in_wid;
  logic [DW-1:0]  csr_in_data;
  logic           csr_out_valid;
  logic           csr_out_ready;
  logic [DW-1:0]  csr_out_data;
  logic [WW-1:0]  alm_empty_wid;
  logic           alm_empty;
  logic           err_overflow;
`ifdef VX_CSR_DRAIN_PERF_EN
  logic [63:0]    perf_drain_cycles;
  logic [31:0]    perf_csr_reqs;
`endif

  vx_csr_drain_gate dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_wid(issue_wid),
    .commit_valid(commit_valid), .commit_wid(commit_wid),
    .csr_in_valid(csr_in_valid), .csr_in_ready(csr_in_ready),
    .csr_in_wid(csr_in_wid), .csr_in_data(csr_in_data),
    .csr_out_valid(csr_out_valid), .csr_out_ready(csr_out_ready),
    .csr_out_data(csr_out_data),
    .alm_empty_wid(alm_empty_wid), .alm_empty(alm_empty),
    .err_overflow(err_overflow)
`ifdef VX_CSR_DRAIN_PERF_EN
    , .perf_drain_cycles(perf_drain_cycles), .perf_csr_reqs(perf_csr_reqs)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending count per warp, one held request.
  int            pend [NW];
  bit            err_m;
  bit            busy;      // a request has been accepted and not yet handed off
  bit            sending;   // the held request is being offered downstream
  int            held_wid;
  logic [DW-1:0] held_data;
  longint        m_drain;
  int            m_reqs;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < NW; w++) pend[w] = 0;
    err_m = 0; busy = 0; sending = 0; held_wid = 0; held_data = '0;
    m_drain = 0; m_reqs = 0;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_wid = '0; commit_valid = '0; commit_wid = '0;
    csr_in_valid = 0; csr_in_wid = '0; csr_in_data = '0; csr_out_ready = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int inc [NW];
    int dec [NW];
    int n;
    for (int w = 0; w < NW; w++) begin
      inc[w] = (issue_valid && int'(issue_wid) == w) ? 1 : 0;
      dec[w] = 0;
    end
    for (int i = 0; i < NC; i++)
      if (commit_valid[i]) dec[int'(commit_wid[i*WW +: WW])]++;
    if ((busy && !sending) || (sending && !csr_out_ready)) m_drain++;
    if (!busy) begin
      if (csr_in_valid) begin
        busy = 1; held_wid = int'(csr_in_wid); held_data = csr_in_data; m_reqs++;
        sending = (pend[held_wid] == 0 && inc[held_wid] == 0);
      end
    end else if (!sending) begin
      if (pend[held_wid] == 0 && inc[held_wid] == 0) sending = 1;
    end else if (csr_out_ready) begin
      busy = 0; sending = 0;
    end
    for (int w = 0; w < NW; w++) begin
      n = pend[w] + inc[w] - dec[w];
      if (n < 0)  begin n = 0;  err_m = 1; end
      if (n > MP) begin n = MP; err_m = 1; end
      pend[w] = n;
    end
  endtask

  // Check outputs mid-cycle, then let one edge pass and update the model.
  task automatic tick();
    #1;
    chk("in_ready", csr_in_ready, !busy);
    chk("out_valid", csr_out_valid, sending);
    if (sending) chk("out_data", csr_out_data, held_data);
    chk("alm_empty", alm_empty, pend[int'(alm_empty_wid)] == 0);
    chk("err_overflow", err_overflow, err_m);
`ifdef VX_CSR_DRAIN_PERF_EN
    chk("perf_drain", perf_drain_cycles, m_drain);
    chk("perf_reqs", perf_csr_reqs, m_reqs);
`endif
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must react immediately.
  task automatic do_reset();
    reset = 1;
    #1;
    model_clear();
    chk("rst_out_valid", csr_out_valid, 1'b0);
    chk("rst_in_ready", csr_in_ready, 1'b1);
    chk("rst_out_data", csr_out_data, '0);
    chk("rst_err", err_overflow, 1'b0);
    chk("rst_alm_empty", alm_empty, 1'b1);
    @(negedge clk);
    reset = 0;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [NC*WW-1:0] one_commit(input int port, input int w);
    logic [NC*WW-1:0] v = '0;
    v[port*WW +: WW] = WW'(w);
    return v;
  endfunction

  initial begin
`ifdef VX_CSR_DRAIN_PERF_EN
    longint p0;
`endif
    idle_inputs();
    alm_empty_wid = '0;
    reset = 1;
    model_clear();
    @(negedge clk);
    do_reset();
    tick();

    // Request for an already drained warp.
    csr_in_valid = 1; csr_in_wid = 2; csr_in_data = rnd_data();
    tick();
    idle_inputs();
    tick();
    chk("drained_latency", csr_out_valid, 1'b1);
    csr_out_ready = 1; tick();
    csr_out_ready = 0; tick();

    // Three issues to warp 1, request, commits at +2, +4, +6.
    alm_empty_wid = 1;
    for (int k = 0; k < 3; k++) begin issue_valid = 1; issue_wid = 1; tick(); end
    idle_inputs();
    csr_in_valid = 1; csr_in_wid = 1; csr_in_data = rnd_data();
    tick();
    idle_inputs();
    for (int k = 1; k <= 8; k++) begin
      commit_valid = '0; commit_wid = '0;
      if (k == 2 || k == 4 || k == 6) begin commit_valid = 4'b0001; commit_wid = one_commit(0, 1); end
      tick();
    end
    idle_inputs();
    csr_out_ready = 1; tick();
    idle_inputs(); tick();

    // Issue and double commit net out, then underflow.
    alm_empty_wid = 0;
    issue_valid = 1; issue_wid = 0; tick();
    issue_valid = 1; issue_wid = 0;
    commit_valid = 4'b0011; commit_wid = one_commit(0, 0) | one_commit(1, 0);
    tick();
    idle_inputs(); tick();
    chk("net_zero_no_err", err_overflow, 1'b0);
    commit_valid = 4'b0001; commit_wid = one_commit(0, 0); tick();
    idle_inputs(); tick();
    chk("underflow_err", err_overflow, 1'b1);

    // Back-pressure in SEND for 5 cycles.
    csr_in_valid = 1; csr_in_wid = 2; csr_in_data = rnd_data(); tick();
    idle_inputs();
`ifdef VX_CSR_DRAIN_PERF_EN
    #1 p0 = perf_drain_cycles; #0;
`endif
    for (int k = 0; k < 5; k++) tick();
`ifdef VX_CSR_DRAIN_PERF_EN
    #1 chk("perf_delta5", perf_drain_cycles - p0, 64'd5);
`endif
    csr_out_ready = 1; tick();
    idle_inputs(); tick();

    // Saturation on warp 3.
    do_reset();
    alm_empty_wid = 3;
    for (int k = 0; k < 16; k++) begin issue_valid = 1; issue_wid = 3; tick(); end
    idle_inputs(); tick();
    chk("sat_err", err_overflow, 1'b1);
    for (int k = 0; k < 15; k++) begin commit_valid = 4'b0100; commit_wid = one_commit(2, 3); tick(); end
    idle_inputs(); tick();
    chk("sat_drained", alm_empty, 1'b1);

    // Reset while draining warp 1 with two in flight.
    do_reset();
    alm_empty_wid = 1;
    for (int k = 0; k < 2; k++) begin issue_valid = 1; issue_wid = 1; tick(); end
    idle_inputs();
    csr_in_valid = 1; csr_in_wid = 1; csr_in_data = rnd_data(); tick();
    idle_inputs(); tick(); tick();
    do_reset();
    tick();
    csr_in_valid = 1; csr_in_wid = 1; csr_in_data = rnd_data(); tick();
    idle_inputs(); tick();
    // Reset while offering downstream.
    do_reset();
    tick();

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      issue_valid   = ($urandom_range(0, 3) == 0);
      issue_wid     = WW'($urandom_range(0, NW - 1));
      for (int i = 0; i < NC; i++) begin
        commit_valid[i] = ($urandom_range(0, 6) == 0);
        commit_wid[i*WW +: WW] = WW'($urandom_range(0, NW - 1));
      end
      csr_in_valid  = ($urandom_range(0, 2) == 0);
      csr_in_wid    = WW'($urandom_range(0, NW - 1));
      csr_in_data   = rnd_data();
      csr_out_ready = ($urandom_range(0, 1) == 0);
      alm_empty_wid = WW'($urandom_range(0, NW - 1));
      tick();
      if (k == 300) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vx_csr_drain_gate.md
Name: vx_csr_drain_gate

Overview:
- Sits directly upstream of the CSR unit: holds each CSR request until all older in-flight instructions of the same warp have committed, then forwards it.
- Restores ordering for CSR reads and writes (counters, fflags, thread masks) that the CSR unit no longer enforces itself.
- Tracks per-warp in-flight counts from issue and commit events.
- Drives an almost-empty status equivalent to the scheduler's alm_empty query.

Parameters:
- NUM_WARPS, 4, number of warps tracked; WID_W = `UP(`CLOG2(NUM_WARPS)).
- NUM_COMMIT, 4, number of commit ports reporting completions per cycle.
- MAX_PENDING, 15, max in-flight instructions per warp; CNT_W = `CLOG2(MAX_PENDING+1).
- DATAW, 128, width of the opaque CSR request payload.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- issue_valid  in  1  one non-CSR instruction issued this cycle
- issue_wid  in  WID_W  warp of the issued instruction
- commit_valid  in  NUM_COMMIT  per-port commit of one instruction (eop)
- commit_wid  in  NUM_COMMIT*WID_W  warp per commit port
- csr_in_valid  in  1  CSR request valid
- csr_in_ready  out  1  request accepted
- csr_in_wid  in  WID_W  warp of the request
- csr_in_data  in  DATAW  request payload, opaque
- csr_out_valid  out  1  request released to the CSR unit
- csr_out_ready  in  1  CSR unit accepts
- csr_out_data  out  DATAW  held payload
- alm_empty_wid  in  WID_W  query warp
- alm_empty  out  1  pending[alm_empty_wid]==0, combinational
- err_overflow  out  1  sticky: a counter saturated or underflowed

Behaviour:
- Reset (async) values: all pending counters 0, state IDLE, csr_out_valid 0, csr_out_data 0, err_overflow 0, csr_in_ready 1.
- Counter update, per warp w, each cycle: pending[w] += (issue_valid && issue_wid==w) - popcount(commit_valid[i] && commit_wid[i]==w).
  - Increment and decrement in the same cycle net out.
  - Arithmetic is done at CNT_W+`CLOG2(NUM_COMMIT+1) bits.
  - A result above MAX_PENDING clamps to MAX_PENDING; a result below 0 clamps to 0. Either case sets err_overflow, and it stays set until reset.
- "Drained(w)" is true when the registered pending[w]==0 and this cycle has no issue_valid for w.
- State IDLE:
  - csr_in_ready=1.
  - On csr_in_valid: capture wid and data into hold registers.
  - Go to SEND if Drained(csr_in_wid), else DRAIN.
- State DRAIN:
  - csr_in_ready=0.
  - Go to SEND in the cycle Drained(held_wid) is true.
- State SEND:
  - csr_in_ready=0, csr_out_valid=1, csr_out_data=held payload, stable until accepted.
  - On csr_out_ready: go to IDLE.
  - No back-to-back bypass: the next request is accepted at the earliest one cycle after out handshake.
- Latency: with an already-drained warp, csr_out_valid rises 1 cycle after accept (registered output). Otherwise it rises 1 cycle after the last commit that brings the count to 0.
- Only one CSR request is in flight; throughput is at most 1 request per 2 cycles.
- An issue for held_wid during DRAIN or SEND is counted but does not reset the state machine. The scheduler guarantees this does not happen because the warp is locked.
- A commit with a warp ID ≥ NUM_WARPS is ignored.
- Reset mid-DRAIN or mid-SEND: the held request is dropped, counters clear, csr_out_valid drops asynchronously.

Optional Feature:
- Macro: VX_CSR_DRAIN_PERF_EN.
- When defined:
  - Adds output perf_drain_cycles (64 bits): counts cycles spent in DRAIN plus SEND cycles with csr_out_ready=0. Resets to 0 and wraps modulo 2^64.
  - Adds output perf_csr_reqs (32 bits): counts accepted requests.
- When undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then a CSR request for warp 2 with all counters 0 -> csr_in_ready=1 at accept, csr_out_valid=1 the next cycle, data equals the input; out_ready=1 -> IDLE with csr_in_ready=1 one cycle later.
- Issue 3 instructions to warp 1, then a CSR request for warp 1; commit them on cycles +2, +4 and +6 -> csr_out_valid stays 0 until the cycle after the third commit; alm_empty(wid=1) is 0 until then.
- Issue to warp 0 while 2 commit ports commit warp 0 in the same cycle, starting from pending=1 -> pending becomes 0 and err_overflow stays 0; a further commit at 0 -> pending stays 0 and err_overflow=1.
- Hold csr_out_ready=0 for 5 cycles in SEND -> csr_out_valid and csr_out_data stay stable and csr_in_ready=0; with the perf macro, perf_drain_cycles increases by 5.
- 16 issues to warp 3 with MAX_PENDING=15 -> pending saturates at 15 and err_overflow=1; 15 commits -> alm_empty(wid=3)=1.
- Assert reset while in DRAIN with pending[1]=2 -> csr_out_valid=0, all counters 0, state IDLE; a new request for warp 1 is released 1 cycle after accept.
